// File: rtl/key_enc_pkg.sv
// ---------------------------------------------------------------------------
// key_enc_pkg
// Shared constants for the key encoder: key-line width, code width, the FSM
// state encodings and a lowest-set-bit priority encoder helper.
// ---------------------------------------------------------------------------
package key_enc_pkg;

    localparam int unsigned KEY_W  = 8;
    localparam int unsigned CODE_W = 3;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HOLD     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    // Index of the lowest-numbered set bit; bit 0 has the highest priority.
    // Returns 0 when no bit is set (callers qualify with their own "any").
    function automatic logic [CODE_W-1:0] lowest_set(input logic [KEY_W-1:0] v);
        lowest_set = '0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_set = CODE_W'(i);
            end
        end
    endfunction

endpackage

// File: rtl/key_sync.sv
// ---------------------------------------------------------------------------
// key_sync
// Two-flop synchronizer for a bus of independent asynchronous lines.
// Both stages reset to all-ones (active-low keys read as released).
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   i_d    - asynchronous input lines
//   o_q    - synchronized lines (two clocks of latency)
// ---------------------------------------------------------------------------
module key_sync #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/key_encoder.sv
// ---------------------------------------------------------------------------
// key_encoder
// Debounced 8-key priority encoder with a valid/ack handshake.
// A key must be stable for DEBOUNCE_CYCLES cycles before its index is
// presented; the event is held until acknowledged, after which all keys must
// be released for DEBOUNCE_CYCLES cycles before a new press is accepted.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   key_n  - asynchronous active-low key lines (bit i low = key i pressed)
//   ack    - consumer acknowledge, only honoured in HOLD
//   code   - binary index of the accepted key
//   valid  - code holds an unacknowledged key event
//   busy   - FSM is not idle
// ---------------------------------------------------------------------------
module key_encoder
    import key_enc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [KEY_W-1:0]  key_n,
    input  logic              ack,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic              busy
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [KEY_W-1:0]  w_key_s;
    logic [KEY_W-1:0]  w_pressed;
    logic              w_any;
    logic [CODE_W-1:0] w_enc;

    logic [1:0]        r_state, w_state_d;
    logic [CNT_W-1:0]  r_cnt,   w_cnt_d;
    logic [CODE_W-1:0] r_cand,  w_cand_d;
    logic [CODE_W-1:0] r_code,  w_code_d;
    logic              r_valid, w_valid_d;

    key_sync #(
        .WIDTH (KEY_W)
    ) u_key_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (key_n),
        .o_q   (w_key_s)
    );

    assign w_pressed = ~w_key_s;
    assign w_any     = |w_pressed;
    assign w_enc     = lowest_set(w_pressed);

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_cand_d  = r_cand;
        w_code_d  = r_code;
        w_valid_d = r_valid;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_cand_d  = w_enc;
                    w_cnt_d   = '0;
                    w_state_d = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                // Adding a higher-numbered key leaves enc unchanged and does
                // not restart the count.
                if (!w_any || (w_enc != r_cand)) begin
                    w_cnt_d   = '0;
                    w_state_d = ST_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_code_d  = r_cand;
                    w_valid_d = 1'b1;
                    w_state_d = ST_HOLD;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (ack) begin
                    w_valid_d = 1'b0;
                    w_cnt_d   = '0;
                    w_state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Any key activity restarts the release qualification.
                if (w_any) begin
                    w_cnt_d = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt_d   = '0;
                    w_state_d = ST_IDLE;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_cnt_d   = '0;
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
            r_code  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_cand  <= w_cand_d;
            r_code  <= w_code_d;
            r_valid <= w_valid_d;
        end
    end

    assign code  = r_code;
    assign valid = r_valid;
    assign busy  = (r_state != ST_IDLE);

endmodule

// File: doc/key_encoder.md
KEY_ENCODER -- requirements
Module: key_encoder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the number of consecutive stable cycles required to accept a press or release; legal range 1..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port key_n, input, 8 bits: asynchronous active-low key lines, bit i low = key i pressed.
REQ-005 The block SHALL have port ack, input, 1 bit: consumer acknowledge of the current code.
REQ-006 The block SHALL have port code, output, 3 bits: binary index of the accepted key.
REQ-007 The block SHALL have port valid, output, 1 bit: high while code holds an unacknowledged key event.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-009 The block SHALL pass key_n through a two-flop synchronizer, producing key_s; all further logic SHALL use key_s only.
REQ-010 The block SHALL derive pressed = ~key_s, any = OR of pressed, and enc = index of the lowest-numbered set bit of pressed (bit 0 highest priority).
REQ-011 The block SHALL implement states IDLE, DEBOUNCE, HOLD and RELEASE, with a debounce counter cnt of width clog2(DEBOUNCE_CYCLES+1).
REQ-012 IDLE: if any is set, the block SHALL latch cand = enc, clear cnt and go to DEBOUNCE; otherwise it SHALL stay in IDLE.
REQ-013 DEBOUNCE: if any is clear or enc differs from cand, the block SHALL return to IDLE with cnt cleared.
REQ-014 DEBOUNCE: otherwise, if cnt equals DEBOUNCE_CYCLES-1, the block SHALL load code = cand, set valid and go to HOLD; otherwise it SHALL increment cnt.
REQ-015 HOLD: valid and code SHALL remain constant until ack is sampled high, regardless of key activity.
REQ-016 HOLD: on the first cycle ack is sampled high, the block SHALL clear valid on that edge, clear cnt and go to RELEASE.
REQ-017 RELEASE: while any is set, the block SHALL clear cnt; while any is clear, it SHALL count.
REQ-018 RELEASE: when cnt equals DEBOUNCE_CYCLES-1 with any clear, the block SHALL go to IDLE.
REQ-019 The block SHALL ignore ack in every state other than HOLD; valid SHALL never rise outside the DEBOUNCE-to-HOLD transition.
REQ-020 Latency: with key_n held stable low, valid SHALL rise on the (DEBOUNCE_CYCLES+3)-th rising edge, counting as edge 1 the first edge that samples key_n low.
REQ-021 Simultaneous presses SHALL report the lowest index only; a second key added during DEBOUNCE that does not change enc SHALL NOT restart debounce.
REQ-022 Outside HOLD, code SHALL retain its last loaded value.
REQ-023 busy SHALL be combinational from state: low in IDLE, high in DEBOUNCE, HOLD and RELEASE.

Reset
REQ-024 While rst_n is low, the block SHALL asynchronously force: state IDLE, cnt 0, cand 0, code 3'd0, valid 0, and both synchronizer stages 8'hFF (all released).
REQ-025 Reset asserted mid-operation, in any state including HOLD with valid high, SHALL discard the pending event without requiring ack.
REQ-026 After reset release, a key still held SHALL be debounced afresh from IDLE.

Structure
REQ-027 A shared package key_enc_pkg SHALL hold the state enumeration (IDLE, DEBOUNCE, HOLD, RELEASE) and the key width constant KEY_W = 8.
REQ-028 The synchronizer SHALL be a sub-module key_sync: parameterized width, reset value all-ones.
REQ-029 The top module SHALL contain the encoder, the state machine and the counter.

Verification (DEBOUNCE_CYCLES = 4)
REQ-030 Single press: key_n = 8'hF7 held -> valid rises on edge 7 with code 3'd3; ack high for 1 cycle -> valid low on the next edge; release -> busy low 6 edges after key_n returns to 8'hFF.
REQ-031 Bounce: key_n toggles 8'hFE/8'hFF every 2 cycles for 20 cycles, then held 8'hFE -> valid never rises during toggling and rises 7 edges after the final hold begins, code 3'd0.
REQ-032 Priority: key_n = 8'h5F (keys 5 and 7 pressed) -> code 3'd5; key 6 added mid-debounce -> same latency, no restart.
REQ-033 Hold without ack: press, then release key 2 for 50 cycles -> valid stays 1 and code stays 3'd2; ack -> RELEASE, then IDLE after 4 clear cycles.
REQ-034 Reset mid-HOLD: rst_n low for 1 cycle while valid = 1 -> valid 0 and code 0 immediately (asynchronous); key still held -> new valid 7 edges after rst_n rises.
REQ-035 Stray ack: ack held high in IDLE and DEBOUNCE -> no effect; valid still rises, and ack clears it on the first edge of HOLD.
